// File: rtl/pcpi_mm_pkg.sv
// Shared opcode/funct3 constants and FSM states for the PCPI systolic
// matrix-multiply coprocessor.
package pcpi_mm_pkg;

   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   localparam logic [2:0] F3_WRITE    = 3'b000;
   localparam logic [2:0] F3_READC    = 3'b001;
   localparam logic [2:0] F3_READMASK = 3'b010;
   localparam logic [2:0] F3_CLEAR    = 3'b101;
   localparam logic [2:0] F3_START    = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_LATCH,
      S_RESP,
      S_HOLD
   } state_t;

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary processing element: forwards a right and b down,
// accumulates a*b (bias loaded on the first step).
module systolic_pe #(
   parameter int DW   = 16,
   parameter int ACCW = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   load_bias,
   input  logic signed [DW-1:0]   a_in,
   input  logic signed [DW-1:0]   b_in,
   input  logic signed [ACCW-1:0] bias,
   output logic signed [DW-1:0]   a_out,
   output logic signed [DW-1:0]   b_out,
   output logic signed [ACCW-1:0] acc
);

   logic signed [2*DW-1:0] prod;
   logic signed [ACCW-1:0] prod_x;
   logic signed [ACCW-1:0] base;

   assign prod   = a_in * b_in;
   assign prod_x = ACCW'(prod);
   assign base   = load_bias ? bias : acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else if (en) begin
         a_out <= a_in;
         b_out <= b_in;
         acc   <= base + prod_x;
      end
   end

endmodule

// File: rtl/pcpi_systolic_mm.sv
// PicoRV32 PCPI coprocessor: NxN systolic C = A*B + bias with per-entry
// readback and threshold mask/popcount.
module pcpi_systolic_mm
   import pcpi_mm_pkg::*;
#(
   parameter int                 N          = 3,
   parameter int                 DW         = 16,
   parameter int                 ACCW       = 32,
   parameter logic signed [31:0] THRESH_RST = -70
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcpi_valid,
   input  logic [31:0] pcpi_insn,
   input  logic [31:0] pcpi_rs1,
   input  logic [31:0] pcpi_rs2,
   output logic        pcpi_wr,
   output logic [31:0] pcpi_rd,
   output logic        pcpi_wait,
   output logic        pcpi_ready
);

   localparam int          NN  = N * N;
   localparam int          IW  = $clog2(NN);
   localparam int          CW  = $clog2(3 * N);
   localparam logic [31:0] NNW = 32'(NN);
   localparam logic [CW-1:0] LAST_STEP = CW'(3 * N - 3);

   state_t               state;
   logic [CW-1:0]        cnt;
   logic signed [DW-1:0] a_mem [NN];
   logic signed [DW-1:0] b_mem [NN];
   logic signed [DW-1:0] bias_mem [NN];
   logic signed [ACCW-1:0] c_mem [NN];
   logic signed [ACCW-1:0] acc_arr [NN];
   logic signed [31:0]   thr;

   logic signed [DW-1:0] row_feed [N];
   logic signed [DW-1:0] col_feed [N];
   logic signed [DW-1:0] a_lnk [N][N+1];
   logic signed [DW-1:0] b_lnk [N+1][N];
   logic [N-1:0]         unused_a;
   logic [N-1:0]         unused_b;
   logic                 unused_bits;

   logic [2:0]  f3;
   logic        hit;
   logic        pe_en;
   logic        ld_bias;
   logic        wr_a, wr_b, wr_bias, wr_thr;
   logic [31:0] off;
   logic [IW-1:0] wi;
   logic [31:0] mask_c;
   logic [31:0] mask_acc;

   assign f3      = pcpi_insn[14:12];
   assign hit     = pcpi_valid && (pcpi_insn[6:0] == OPC_CUSTOM0) &&
                    (f3 inside {F3_WRITE, F3_READC, F3_READMASK,
                                F3_CLEAR, F3_START});
   assign pe_en   = (state == S_RUN);
   assign ld_bias = (cnt == '0);
   assign wi      = off[IW-1:0];
   assign unused_bits = ^{pcpi_insn[31:15], pcpi_insn[11:7], off[31:IW],
                          unused_a, unused_b};

   always_comb begin
      wr_a    = 1'b0;
      wr_b    = 1'b0;
      wr_bias = 1'b0;
      wr_thr  = 1'b0;
      off     = pcpi_rs1;
      if (pcpi_rs1 < NNW) begin
         wr_a = 1'b1;
      end else if (pcpi_rs1 < 2 * NNW) begin
         wr_b = 1'b1;
         off  = pcpi_rs1 - NNW;
      end else if (pcpi_rs1 < 3 * NNW) begin
         wr_bias = 1'b1;
         off     = pcpi_rs1 - 2 * NNW;
      end else if (pcpi_rs1 == 3 * NNW) begin
         wr_thr = 1'b1;
      end
   end

   // Skewed feed: row r sees A[r][k-r], column c sees B[k-c][c].
   always_comb begin
      for (int r = 0; r < N; r++) begin
         row_feed[r] = '0;
         col_feed[r] = '0;
      end
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) begin
            if (32'(cnt) == 32'(r + j)) begin
               row_feed[r] = a_mem[r*N+j];
               col_feed[r] = b_mem[j*N+r];
            end
         end
      end
   end

   always_comb begin
      mask_c   = '0;
      mask_acc = '0;
      for (int i = 0; i < NN; i++) begin
         mask_c[i]   = $signed(32'(c_mem[i])) >= thr;
         mask_acc[i] = $signed(32'(acc_arr[i])) >= thr;
      end
   end

   for (genvar r = 0; r < N; r++) begin : g_row
      assign a_lnk[r][0] = row_feed[r];
      assign b_lnk[0][r] = col_feed[r];
      assign unused_a[r] = ^a_lnk[r][N];
      assign unused_b[r] = ^b_lnk[N][r];
      for (genvar c = 0; c < N; c++) begin : g_col
         systolic_pe #(
            .DW   (DW),
            .ACCW (ACCW)
         ) u_pe (
            .clk       (clk),
            .rst       (rst),
            .en        (pe_en),
            .load_bias (ld_bias),
            .a_in      (a_lnk[r][c]),
            .b_in      (b_lnk[r][c]),
            .bias      (ACCW'(bias_mem[r*N+c])),
            .a_out     (a_lnk[r][c+1]),
            .b_out     (b_lnk[r+1][c]),
            .acc       (acc_arr[r*N+c])
         );
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         pcpi_wr    <= 1'b0;
         pcpi_rd    <= '0;
         pcpi_wait  <= 1'b0;
         pcpi_ready <= 1'b0;
         thr        <= THRESH_RST;
         for (int i = 0; i < NN; i++) begin
            a_mem[i]    <= '0;
            b_mem[i]    <= '0;
            bias_mem[i] <= '0;
            c_mem[i]    <= '0;
         end
      end else begin
         unique case (state)
            S_IDLE: if (hit) begin
               if (f3 == F3_START) begin
                  state     <= S_RUN;
                  cnt       <= '0;
                  pcpi_wait <= 1'b1;
               end else begin
                  state      <= S_RESP;
                  pcpi_ready <= 1'b1;
                  pcpi_wr    <= (f3 == F3_READC) || (f3 == F3_READMASK);
               end
               case (f3)
                  F3_WRITE: begin
                     if (wr_a)    a_mem[wi]    <= pcpi_rs2[DW-1:0];
                     if (wr_b)    b_mem[wi]    <= pcpi_rs2[DW-1:0];
                     if (wr_bias) bias_mem[wi] <= pcpi_rs2[DW-1:0];
                     if (wr_thr)  thr          <= pcpi_rs2;
                  end
                  F3_READC:
                     pcpi_rd <= (pcpi_rs1 < NNW) ?
                                32'(c_mem[pcpi_rs1[IW-1:0]]) : '0;
                  F3_READMASK: pcpi_rd <= mask_c;
                  F3_CLEAR:
                     for (int i = 0; i < NN; i++) c_mem[i] <= '0;
                  default: ;
               endcase
            end
            S_RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST_STEP) state <= S_LATCH;
            end
            S_LATCH: begin
               for (int i = 0; i < NN; i++) c_mem[i] <= acc_arr[i];
               pcpi_rd    <= 32'($countones(mask_acc));
               pcpi_ready <= 1'b1;
               pcpi_wr    <= 1'b1;
               pcpi_wait  <= 1'b0;
               state      <= S_RESP;
            end
            S_RESP: begin
               pcpi_ready <= 1'b0;
               pcpi_wr    <= 1'b0;
               pcpi_rd    <= '0;
               state      <= S_HOLD;
            end
            S_HOLD: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcpi_systolic_mm.sv
// Self-checking bench for pcpi_systolic_mm (N=3): directed vector table,
// hand-written handshake corner cases and randomized runs against a model.
module tb_pcpi_systolic_mm;
   import pcpi_mm_pkg::*;

   localparam int N  = 3;
   localparam int NN = 9;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] rd;
      logic        wr;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pcpi_valid = 1'b0;
   logic [31:0] pcpi_insn = '0;
   logic [31:0] pcpi_rs1 = '0;
   logic [31:0] pcpi_rs2 = '0;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;

   int checks = 0;
   int failures = 0;

   int ma [NN];
   int mb [NN];
   int mbias [NN];
   int mc [NN];
   int mthr;

   always #5 clk = ~clk;

   pcpi_systolic_mm #(
      .N          (3),
      .DW         (16),
      .ACCW       (32),
      .THRESH_RST (-70)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pcpi_valid (pcpi_valid),
      .pcpi_insn  (pcpi_insn),
      .pcpi_rs1   (pcpi_rs1),
      .pcpi_rs2   (pcpi_rs2),
      .pcpi_wr    (pcpi_wr),
      .pcpi_rd    (pcpi_rd),
      .pcpi_wait  (pcpi_wait),
      .pcpi_ready (pcpi_ready)
   );

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h expected=0x%08h", nm, got, exp);
      end
   endtask

   function automatic logic [31:0] mkinsn(input logic [2:0] f3,
                                          input logic [6:0] opc);
      return {17'b0, f3, 5'b0, opc};
   endfunction

   function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [31:0] rd,
                               input logic wr, input int lat);
      vec_t v;
      v.f3 = f3; v.rs1 = r1; v.rs2 = r2; v.rd = rd; v.wr = wr; v.lat = lat;
      return v;
   endfunction

   // lat = number of rising edges from the sampling edge to visible ready
   task automatic do_op(input logic [2:0] f3, input logic [31:0] r1,
                        input logic [31:0] r2, output logic [31:0] rd,
                        output logic wr, output int lat, output int waits);
      @(negedge clk);
      pcpi_valid = 1'b1;
      pcpi_insn  = mkinsn(f3, OPC_CUSTOM0);
      pcpi_rs1   = r1;
      pcpi_rs2   = r2;
      lat = 0; waits = 0; rd = '0; wr = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (pcpi_wait) waits++;
         if (pcpi_ready) begin
            lat = i; rd = pcpi_rd; wr = pcpi_wr;
            break;
         end
      end
      pcpi_valid = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic write_m(input int idx, input int val);
      logic [31:0] rd; logic wr; int lat, wt;
      do_op(F3_WRITE, 32'(idx), 32'(val), rd, wr, lat, wt);
      if (lat == 0) begin
         failures++; checks++;
         $display("FAIL write_timeout idx=%0d got=no_ready expected=ready", idx);
      end
   endtask

   function automatic void model_c();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            int s;
            s = mbias[i*N+j];
            for (int k = 0; k < N; k++) s += ma[i*N+k] * mb[k*N+j];
            mc[i*N+j] = s;
         end
   endfunction

   function automatic logic [31:0] model_mask();
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < NN; i++) m[i] = (mc[i] >= mthr);
      return m;
   endfunction

   function automatic int rnd16(input int mode);
      logic [15:0] v;
      if (mode == 0) return int'($urandom_range(0, 20)) - 10;
      v = 16'($urandom);
      return int'($signed(v));
   endfunction

   initial begin
      vec_t tbl[$];
      logic [31:0] rd;
      logic wr;
      int lat, wt, nready, nwait;
      logic [31:0] m;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", {31'b0, pcpi_ready}, 32'd0);
      chk("reset_wait", {31'b0, pcpi_wait}, 32'd0);
      chk("reset_wr", {31'b0, pcpi_wr}, 32'd0);
      chk("reset_rd", pcpi_rd, 32'd0);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);

      // identity A, B = 1..9, thr 5
      for (int i = 0; i < NN; i++)
         tbl.push_back(mk(F3_WRITE, 32'(i), (i % 4 == 0) ? 1 : 0, 0, 0, 1));
      for (int i = 0; i < NN; i++)
         tbl.push_back(mk(F3_WRITE, 32'(9 + i), 32'(i + 1), 0, 0, 1));
      tbl.push_back(mk(F3_WRITE, 27, 5, 0, 0, 1));
      tbl.push_back(mk(F3_START, 0, 0, 5, 1, 9));
      tbl.push_back(mk(F3_READMASK, 0, 0, 32'h1F0, 1, 1));
      tbl.push_back(mk(F3_READC, 8, 0, 9, 1, 1));
      tbl.push_back(mk(F3_READC, 9, 0, 0, 1, 1));
      // A=-2, B=3, bias00=100, thr -20
      for (int i = 0; i < NN; i++) begin
         tbl.push_back(mk(F3_WRITE, 32'(i), 32'hFFFF_FFFE, 0, 0, 1));
         tbl.push_back(mk(F3_WRITE, 32'(9 + i), 3, 0, 0, 1));
      end
      tbl.push_back(mk(F3_WRITE, 18, 100, 0, 0, 1));
      tbl.push_back(mk(F3_WRITE, 27, 32'hFFFF_FFEC, 0, 0, 1));
      tbl.push_back(mk(F3_START, 0, 0, 9, 1, 9));
      tbl.push_back(mk(F3_READC, 0, 0, 82, 1, 1));
      tbl.push_back(mk(F3_READC, 4, 0, 32'hFFFF_FFEE, 1, 1));
      tbl.push_back(mk(F3_WRITE, 27, 32'hFFFF_FFEF, 0, 0, 1));
      tbl.push_back(mk(F3_READMASK, 0, 0, 32'h001, 1, 1));
      // full-scale negative operands wrap the accumulator
      for (int i = 0; i < NN; i++) begin
         tbl.push_back(mk(F3_WRITE, 32'(i), 32'hFFFF_8000, 0, 0, 1));
         tbl.push_back(mk(F3_WRITE, 32'(9 + i), 32'hFFFF_8000, 0, 0, 1));
      end
      tbl.push_back(mk(F3_WRITE, 18, 0, 0, 0, 1));
      tbl.push_back(mk(F3_START, 0, 0, 0, 1, 9));
      tbl.push_back(mk(F3_READC, 8, 0, 32'hC000_0000, 1, 1));
      tbl.push_back(mk(F3_WRITE, 100, 7, 0, 0, 1));
      tbl.push_back(mk(F3_CLEAR, 0, 0, 0, 0, 1));
      tbl.push_back(mk(F3_READC, 0, 0, 0, 1, 1));

      foreach (tbl[i]) begin
         do_op(tbl[i].f3, tbl[i].rs1, tbl[i].rs2, rd, wr, lat, wt);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
         chk($sformatf("vec%0d_wr", i), {31'b0, wr}, {31'b0, tbl[i].wr});
         if (tbl[i].wr) chk($sformatf("vec%0d_rd", i), rd, tbl[i].rd);
         if (tbl[i].f3 == F3_START)
            chk($sformatf("vec%0d_waits", i), 32'(wt), 32'd8);
         else
            chk($sformatf("vec%0d_waits", i), 32'(wt), 32'd0);
      end

      // unsupported funct3 / opcode held: never answered
      @(negedge clk);
      pcpi_valid = 1'b1;
      pcpi_insn  = mkinsn(3'b011, OPC_CUSTOM0);
      nready = 0; nwait = 0;
      repeat (20) begin
         @(posedge clk); #1;
         nready += int'(pcpi_ready); nwait += int'(pcpi_wait);
      end
      pcpi_insn = mkinsn(F3_START, 7'b0110011);
      repeat (10) begin
         @(posedge clk); #1;
         nready += int'(pcpi_ready); nwait += int'(pcpi_wait);
      end
      pcpi_valid = 1'b0;
      chk("unknown_ready", 32'(nready), 32'd0);
      chk("unknown_wait", 32'(nwait), 32'd0);

      // valid held past ready: one run, one pulse
      @(negedge clk);
      pcpi_valid = 1'b1;
      pcpi_insn  = mkinsn(F3_START, OPC_CUSTOM0);
      nready = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (pcpi_ready) begin nready++; break; end
      end
      repeat (2) begin
         @(posedge clk); #1;
         nready += int'(pcpi_ready);
      end
      pcpi_valid = 1'b0;
      nwait = 0;
      repeat (20) begin
         @(posedge clk); #1;
         nready += int'(pcpi_ready); nwait += int'(pcpi_wait);
      end
      chk("held_valid_ready_pulses", 32'(nready), 32'd1);
      chk("held_valid_no_rerun", 32'(nwait), 32'd0);

      // valid dropped mid-run: still completes
      @(negedge clk);
      pcpi_valid = 1'b1;
      pcpi_insn  = mkinsn(F3_START, OPC_CUSTOM0);
      repeat (3) @(posedge clk);
      #1 pcpi_valid = 1'b0;
      nready = 0;
      repeat (30) begin
         @(posedge clk); #1;
         nready += int'(pcpi_ready);
      end
      chk("drop_valid_ready", 32'(nready), 32'd1);

      // reset in the middle of a run
      write_m(27, 5);
      @(negedge clk);
      pcpi_valid = 1'b1;
      pcpi_insn  = mkinsn(F3_START, OPC_CUSTOM0);
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("run_wait_before_rst", {31'b0, pcpi_wait}, 32'd1);
      rst = 1'b1; pcpi_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_wait_low", {31'b0, pcpi_wait}, 32'd0);
      chk("rst_ready_low", {31'b0, pcpi_ready}, 32'd0);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);
      do_op(F3_READC, 0, 0, rd, wr, lat, wt);
      chk("rst_readc0", rd, 32'd0);
      do_op(F3_READMASK, 0, 0, rd, wr, lat, wt);
      chk("rst_thr_mask", rd, 32'h1FF);
      do_op(F3_START, 0, 0, rd, wr, lat, wt);
      chk("rst_ops_cleared", rd, 32'd9);

      // randomized runs against the arithmetic model
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < NN; i++) begin
            ma[i] = rnd16(it % 2);
            mb[i] = rnd16(it % 2);
            mbias[i] = rnd16(it % 2);
            write_m(i, ma[i]);
            write_m(9 + i, mb[i]);
            write_m(18 + i, mbias[i]);
         end
         model_c();
         if (it % 2 == 0) mthr = mc[$urandom_range(0, NN - 1)];
         else mthr = int'($urandom_range(0, 400)) - 200;
         write_m(27, mthr);
         m = model_mask();
         do_op(F3_START, 0, 0, rd, wr, lat, wt);
         chk($sformatf("rnd%0d_popcount", it), rd, 32'($countones(m)));
         chk($sformatf("rnd%0d_start_lat", it), 32'(lat), 32'd9);
         do_op(F3_READMASK, 0, 0, rd, wr, lat, wt);
         chk($sformatf("rnd%0d_mask", it), rd, m);
         for (int i = 0; i < NN; i++) begin
            do_op(F3_READC, 32'(i), 0, rd, wr, lat, wt);
            chk($sformatf("rnd%0d_c%0d", it, i), rd, 32'(mc[i]));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
